priority_arbiter_rr: RTL
========================

// Module: priority_arbiter_rr
// PURPOSE
//  Parametrised N-requester arbiter built around a priority encoder core; registered one-hot grant.
//  Two modes, selected at runtime: fixed MSB-first priority, or round-robin with a rotating pointer.
//  A grant is held until the grantee signals done or withdraws its request.
//  Sits in front of shared resources (bus, memory port) that several masters compete for.
// PARAMETERS
//  N      8            number of requesters, N >= 2, non-power-of-two allowed
//  IDX_W  $clog2(N)    width of grant index
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  mode       in   1      0 = fixed MSB priority, 1 = round-robin
//  req        in   N      request vector, any number of bits may be high
//  done       in   1      grantee finished; releases the current grant
//  gnt        out  N      one-hot grant (registered), all-zero when no grant
//  gnt_idx    out  IDX_W  binary index of gnt bit (registered), 0 when no grant
//  gnt_valid  out  1      high while a grant is held (registered)
// BEHAVIOUR
//  - Reset (clk edge with rst=1): gnt=0, gnt_idx=0, gnt_valid=0, ptr=N-1, state=IDLE.
//    Reset overrides every other input, including mid-grant.
//  - States: IDLE (no grant held), BUSY (grant held).
//  - Arbitration function sel(v):
//    mode 0: highest set index of v.
//    mode 1: first set index searching ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (wrap-around).
//    An all-zero v gives no winner.
//  - IDLE: if |req, the next edge registers gnt=1<<sel(req), gnt_idx=sel(req), gnt_valid=1,
//    and the state becomes BUSY. Latency req->gnt is 1 cycle. If req==0, stay IDLE, outputs 0.
//  - BUSY, release condition: done=1 OR req[gnt_idx]=0. Without a release, all outputs hold.
//  - On release with v = req & ~gnt:
//    mode 1: ptr <= (gnt_idx==0) ? N-1 : gnt_idx-1, updated on the same edge.
//    mode 0: ptr is unchanged.
//    If v!=0, the next grant is sel(v), evaluated with the updated ptr. Grants are back-to-back with
//    no idle cycle, and the state stays BUSY.
//    If v==0, outputs clear and the state returns to IDLE.
//  - A grantee never wins two consecutive arbitrations; it must appear again after another winner or IDLE.
//  - done while IDLE is ignored. Bits of req change freely; only req[gnt_idx] matters while BUSY.
//  - mode is sampled only at an arbitration edge; a change while BUSY does not disturb the current grant.
//    ptr is retained across mode changes.
//  - Invariant: gnt is one-hot or zero, gnt_valid == |gnt, gnt == 1<<gnt_idx when valid.
// STRUCTURE
//  - Package arb_pkg: state enum {ARB_IDLE, ARB_BUSY}; constants MODE_FIXED=1'b0, MODE_RR=1'b1.
//  - Sub-module prio_enc_msb #(N): combinational MSB-first encoder giving idx and any.
//  - Round-robin uses two prio_enc_msb instances:
//    masked: bits <= ptr;
//    unmasked: the full vector, used when the masked result is empty.
//  - Top level holds the FSM, ptr register and output registers.
// TESTING (N=8 unless noted)
//  1 mode=0, req=8'b0010_1100 -> after 1 edge gnt=8'b0010_0000, gnt_idx=5, gnt_valid=1; holds 10 cycles with done=0.
//  2 mode=1, req=8'hFF constant, done pulsed 1 cycle after each grant -> grant order 7,6,5,4,3,2,1,0,7 (wrap),
//    no idle cycles between grants.
//  3 Grant held on idx 3, then req[3] drops with req=8'b0000_0001 -> next edge gnt=8'b0000_0001, gnt_idx=0.
//    Then req drops to 0 -> outputs 0, state IDLE.
//  4 mode=0, req=8'b1000_0001, done pulsed after grant 7 -> next grant idx 0 (no repeat of 7).
//    req[7] stays high and done is pulsed again -> grant idx 7.
//  5 rst=1 asserted while BUSY on idx 4 -> next edge gnt=0, gnt_valid=0, ptr=7.
//    After rst falls, mode=1, req=8'hFF -> grant idx 7.
//  6 N=5: mode=1, req=5'b11111 with repeated done -> order 4,3,2,1,0,4; gnt_idx never exceeds 4.
//    Check the one-hot invariant every cycle in all runs.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the priority / round-robin arbiter.
//   arb_state_t : arbiter FSM state (IDLE = no grant held, BUSY = grant held)
//   MODE_FIXED  : value of the mode input selecting fixed MSB-first priority
//   MODE_RR     : value of the mode input selecting round-robin arbitration
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/prio_enc_msb.sv
// Combinational MSB-first priority encoder.
//   vec : input vector, any number of bits may be set
//   idx : index of the highest set bit of vec, 0 when vec is all-zero
//   any : high when at least one bit of vec is set
module prio_enc_msb #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last set bit visited is the highest one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : prio_enc_msb

// File: rtl/priority_arbiter_rr.sv
// N-requester arbiter with a registered one-hot grant.
// Runtime-selectable policy: fixed MSB-first priority or round-robin with a
// rotating pointer. A grant is held until the grantee raises done or drops
// its request; the next winner is then granted on the same edge.
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   mode      : 0 = fixed MSB priority, 1 = round-robin
//   req       : request vector
//   done      : grantee finished, releases the current grant
//   gnt       : one-hot grant, zero when no grant held
//   gnt_idx   : binary index of the granted requester, 0 when no grant
//   gnt_valid : high while a grant is held
module priority_arbiter_rr
    import arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N - 1);
    localparam logic [N-1:0]     ONE      = N'(1);

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [N-1:0]     gnt_reg, gnt_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic             gnt_valid_reg, gnt_valid_next;

    logic             release_grant;
    logic [IDX_W-1:0] release_ptr;
    logic [N-1:0]     arb_vec;
    logic [IDX_W-1:0] arb_ptr;
    logic [N-1:0]     ptr_mask;
    logic [N-1:0]     masked_vec;
    logic [IDX_W-1:0] masked_idx, full_idx, sel_idx;
    logic             masked_any, full_any;

    // Release of the current grant and the pointer it would leave behind:
    // the slot just below the grantee, wrapping to the top.
    assign release_grant = done | ~req[gnt_idx_reg];
    assign release_ptr   = (gnt_idx_reg == '0) ? PTR_INIT : gnt_idx_reg - IDX_W'(1);

    // Arbitration operands. While BUSY the current grantee is excluded so it
    // cannot win twice in a row, and in round-robin the search starts from
    // the pointer being written on this same edge.
    always_comb begin
        arb_vec = req;
        arb_ptr = ptr_reg;
        if (state_reg == ARB_BUSY) begin
            arb_vec = req & ~gnt_reg;
            if (mode == MODE_RR) begin
                arb_ptr = release_ptr;
            end
        end
    end

    // Bits at or below the pointer are searched first (downwards from ptr).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign ptr_mask[gi] = (IDX_W'(gi) <= arb_ptr);
        end
    endgenerate

    assign masked_vec = arb_vec & ptr_mask;

    prio_enc_msb #(.N(N), .IDX_W(IDX_W)) u_enc_masked (
        .vec (masked_vec),
        .idx (masked_idx),
        .any (masked_any)
    );

    prio_enc_msb #(.N(N), .IDX_W(IDX_W)) u_enc_full (
        .vec (arb_vec),
        .idx (full_idx),
        .any (full_any)
    );

    // Round-robin wraps to the unmasked result (highest index above ptr)
    // when nothing at or below the pointer is requesting.
    assign sel_idx = (mode == MODE_RR && masked_any) ? masked_idx : full_idx;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        gnt_next       = gnt_reg;
        gnt_idx_next   = gnt_idx_reg;
        gnt_valid_next = gnt_valid_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (full_any) begin
                    state_next     = ARB_BUSY;
                    gnt_next       = ONE << sel_idx;
                    gnt_idx_next   = sel_idx;
                    gnt_valid_next = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (release_grant) begin
                    if (mode == MODE_RR) begin
                        ptr_next = release_ptr;
                    end
                    if (full_any) begin
                        gnt_next       = ONE << sel_idx;
                        gnt_idx_next   = sel_idx;
                        gnt_valid_next = 1'b1;
                    end else begin
                        state_next     = ARB_IDLE;
                        gnt_next       = '0;
                        gnt_idx_next   = '0;
                        gnt_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next     = ARB_IDLE;
                gnt_next       = '0;
                gnt_idx_next   = '0;
                gnt_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            ptr_reg       <= PTR_INIT;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;

endmodule : priority_arbiter_rr
